stage_wb_trap: RTL and testbench

//  Parametrised write-back trap controller; the next generation of WB exception handling.

---
 rtl/stage_wb_trap.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_stage_wb_trap.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_wb_trap.sv
// stage_wb_trap -- write-back trap controller.
//
// Sits in WB next to the register-file write mux. Decides whether the
// retiring instruction takes an interrupt or an exception, or executes mret.
// It keeps the M-mode trap CSRs and issues a registered one-cycle redirect
// to fetch. A short FLUSH state then stalls the pipe for FLUSH_CYCLES cycles.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   valid_i, pc_i           retiring instruction qualifier and its PC
//   instruction_i           raw instruction word (mtval on illegal)
//   mem_addr_i              load/store effective address (mtval on misalign)
//   e_*_i                   exception flags of the retiring instruction
//   is_mret_i               retiring instruction is mret
//   xint_m{e,t,s}ip_i       level interrupt requests (external/timer/software)
//   plat_irq_i              level platform interrupts, causes 16..16+N-1
//   csr_we_i/addr/wdata     CSR write from the retiring Zicsr op
//   csr_rdata_o             combinational CSR read data (0 if unimplemented)
//   kill_wb_o               suppress RF/CSR commit of the retiring instruction
//   trap_o, trap_pc_o       registered redirect strobe and target
//   stall_o                 high while the FLUSH sequencer runs
module stage_wb_trap #(
  parameter int          XLEN         = 32,
  parameter int          NUM_PLAT_IRQ = 4,
  parameter logic [63:0] RESET_MTVEC  = 64'h100,
  parameter bit          VECTORED_EN  = 1'b1,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          valid_i,
  input  logic [XLEN-1:0]                               pc_i,
  input  logic [31:0]                                   instruction_i,
  input  logic [XLEN-1:0]                               mem_addr_i,
  input  logic                                          e_inst_addr_mis_i,
  input  logic                                          e_illegal_inst_i,
  input  logic                                          e_break_i,
  input  logic                                          e_ecall_i,
  input  logic                                          e_ld_addr_mis_i,
  input  logic                                          e_st_addr_mis_i,
  input  logic                                          is_mret_i,
  input  logic                                          xint_meip_i,
  input  logic                                          xint_mtip_i,
  input  logic                                          xint_msip_i,
  input  logic [((NUM_PLAT_IRQ > 0) ? NUM_PLAT_IRQ : 1)-1:0] plat_irq_i,
  input  logic                                          csr_we_i,
  input  logic [11:0]                                   csr_addr_i,
  input  logic [XLEN-1:0]                               csr_wdata_i,
  output logic [XLEN-1:0]                               csr_rdata_o,
  output logic                                          kill_wb_o,
  output logic                                          trap_o,
  output logic [XLEN-1:0]                               trap_pc_o,
  output logic                                          stall_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  // Counter only ever holds FLUSH_CYCLES-1 down to 0.
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  // Writable bits of mie: MSIE, MTIE, MEIE and one bit per platform line.
  function automatic logic [XLEN-1:0] mie_mask_f();
    logic [XLEN-1:0] m;
    m     = '0;
    m[3]  = 1'b1;
    m[7]  = 1'b1;
    m[11] = 1'b1;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) m[16+i] = 1'b1;
    return m;
  endfunction

  // Fixed interrupt priority: MEI > MSI > MTI > plat[0] > ... > plat[N-1].
  // Lower priority sources are assigned first so higher ones overwrite them.
  // Returns {any, code}.
  function automatic logic [5:0] irq_select_f(input logic [XLEN-1:0] pend);
    logic [5:0] r;
    r = 6'b0;
    for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
      if (pend[16+i]) r = {1'b1, 5'(16 + i)};
    end
    if (pend[7])  r = {1'b1, 5'd7};
    if (pend[3])  r = {1'b1, 5'd3};
    if (pend[11]) r = {1'b1, 5'd11};
    return r;
  endfunction

  localparam logic [XLEN-1:0] MIE_MASK   = mie_mask_f();
  localparam logic [XLEN-1:0] MTVEC_RST  =
    {RESET_MTVEC[XLEN-1:2], 1'b0, VECTORED_EN & RESET_MTVEC[0]};

  // Architectural state
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mst_mie_q, mst_mie_d;
  logic              mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0]   mie_q, mie_d;
  logic [XLEN-1:0]   mtvec_q, mtvec_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   mtval_q, mtval_d;
  logic [XLEN-1:0]   mscratch_q, mscratch_d;
  logic              trap_q, trap_d;
  logic [XLEN-1:0]   trap_pc_q, trap_pc_d;

  // Decode
  logic [XLEN-1:0]   mip_s;
  logic [XLEN-1:0]   mstatus_s;
  logic [5:0]        irq_sel_s;
  logic              exc_any_s;
  logic [4:0]        exc_code_s;
  logic [XLEN-1:0]   exc_tval_s;
  logic              run_s;
  logic              stall_s;
  logic              irq_take_s;
  logic              trap_take_s;
  logic              mret_take_s;
  logic              csr_wr_s;
  logic [XLEN-1:0]   tvec_base_s;
  logic [XLEN-1:0]   target_s;

  // mip mirrors the request lines; mstatus is assembled from its live bits.
  always_comb begin
    mip_s     = '0;
    mip_s[3]  = xint_msip_i;
    mip_s[7]  = xint_mtip_i;
    mip_s[11] = xint_meip_i;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) mip_s[16+i] = plat_irq_i[i];
    mstatus_s        = '0;
    mstatus_s[12:11] = 2'b11;
    mstatus_s[7]     = mst_mpie_q;
    mstatus_s[3]     = mst_mie_q;
  end

  assign irq_sel_s = irq_select_f(mie_q & mip_s);

  // Synchronous exception priority and the matching mtval value.
  always_comb begin
    exc_any_s  = 1'b1;
    exc_code_s = 5'd0;
    exc_tval_s = '0;
    if (e_inst_addr_mis_i) begin
      exc_code_s = 5'd0;
      exc_tval_s = pc_i;
    end else if (e_illegal_inst_i) begin
      exc_code_s = 5'd2;
      exc_tval_s = XLEN'(instruction_i);
    end else if (e_break_i) begin
      exc_code_s = 5'd3;
    end else if (e_ecall_i) begin
      exc_code_s = 5'd11;
    end else if (e_ld_addr_mis_i) begin
      exc_code_s = 5'd4;
      exc_tval_s = mem_addr_i;
    end else if (e_st_addr_mis_i) begin
      exc_code_s = 5'd6;
      exc_tval_s = mem_addr_i;
    end else begin
      exc_any_s = 1'b0;
    end
  end

  // Interrupts outrank exceptions, and both outrank mret.
  assign irq_take_s  = valid_i & run_s & mst_mie_q & irq_sel_s[5];
  assign trap_take_s = irq_take_s | (valid_i & run_s & exc_any_s);
  assign mret_take_s = valid_i & run_s & is_mret_i & ~trap_take_s;
  assign kill_wb_o   = valid_i & run_s & (irq_take_s | exc_any_s | is_mret_i);
  assign csr_wr_s    = valid_i & run_s & csr_we_i & ~kill_wb_o;

  // Vectored mode only offsets interrupt targets; exceptions use the base.
  assign tvec_base_s = {mtvec_q[XLEN-1:2], 2'b00};
  assign target_s    = (irq_take_s & mtvec_q[0])
                     ? tvec_base_s + (XLEN'(irq_sel_s[4:0]) << 2)
                     : tvec_base_s;

  // CSR next-state: trap entry, mret, or a software write (in that order).
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mscratch_d = mscratch_q;
    if (trap_take_s) begin
      mepc_d             = {pc_i[XLEN-1:2], 2'b00};
      mcause_d           = '0;
      mcause_d[XLEN-1]   = irq_take_s;
      mcause_d[4:0]      = irq_take_s ? irq_sel_s[4:0] : exc_code_s;
      mtval_d            = irq_take_s ? '0 : exc_tval_s;
      mst_mpie_d         = mst_mie_q;
      mst_mie_d          = 1'b0;
    end else if (mret_take_s) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (csr_wr_s) begin
      case (csr_addr_i)
        ADDR_MSTATUS: begin
          mst_mie_d  = csr_wdata_i[3];
          mst_mpie_d = csr_wdata_i[7];
        end
        ADDR_MIE:      mie_d      = csr_wdata_i & MIE_MASK;
        ADDR_MTVEC:    mtvec_d    = {csr_wdata_i[XLEN-1:2], 1'b0,
                                     VECTORED_EN & csr_wdata_i[0]};
        ADDR_MEPC:     mepc_d     = {csr_wdata_i[XLEN-1:2], 2'b00};
        ADDR_MCAUSE:   mcause_d   = csr_wdata_i;
        ADDR_MTVAL:    mtval_d    = csr_wdata_i;
        ADDR_MSCRATCH: mscratch_d = csr_wdata_i;
        default:       mscratch_d = mscratch_q;
      endcase
    end else begin
      mscratch_d = mscratch_q;
    end
  end

  // Redirect strobe lasts exactly one cycle; the target is held afterwards.
  always_comb begin
    trap_d    = 1'b0;
    trap_pc_d = trap_pc_q;
    if (trap_take_s) begin
      trap_d    = 1'b1;
      trap_pc_d = target_s;
    end else if (mret_take_s) begin
      trap_d    = 1'b1;
      trap_pc_d = mepc_q;
    end else begin
      trap_d = 1'b0;
    end
  end

  // CSR and redirect registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mscratch_q <= '0;
      trap_q     <= 1'b0;
      trap_pc_q  <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mscratch_q <= mscratch_d;
      trap_q     <= trap_d;
      trap_pc_q  <= trap_pc_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: FLUSH lasts FLUSH_CYCLES cycles, counted down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (trap_take_s | mret_take_s) begin
          state_d = ST_FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    run_s   = (state_q == ST_RUN);
    stall_s = (state_q == ST_FLUSH);
  end

  // CSR read mux.
  always_comb begin
    case (csr_addr_i)
      ADDR_MSTATUS:  csr_rdata_o = mstatus_s;
      ADDR_MIE:      csr_rdata_o = mie_q;
      ADDR_MIP:      csr_rdata_o = mip_s;
      ADDR_MTVEC:    csr_rdata_o = mtvec_q;
      ADDR_MEPC:     csr_rdata_o = mepc_q;
      ADDR_MCAUSE:   csr_rdata_o = mcause_q;
      ADDR_MTVAL:    csr_rdata_o = mtval_q;
      ADDR_MSCRATCH: csr_rdata_o = mscratch_q;
      default:       csr_rdata_o = '0;
    endcase
  end

  assign trap_o    = trap_q;
  assign trap_pc_o = trap_pc_q;
  assign stall_o   = stall_s;

endmodule

// File: tb/tb_stage_wb_trap.sv
// Directed bench for stage_wb_trap. Two instances share all inputs: one with
// vectored mtvec enabled (dut1) and one with it disabled (dut0). The expected
// redirect targets are queued when a trapping instruction is driven and
// popped when the redirect strobe appears.
module tb_stage_wb_trap;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, is_mret, meip, mtip, msip, csr_we;
  logic        e_im, e_ill, e_brk, e_ecall, e_ld, e_st;
  logic [31:0] pc, insn, mem_addr, wdata;
  logic [3:0]  plat;
  logic [11:0] caddr;
  logic [31:0] rdata1, rdata0, tpc1, tpc0;
  logic        kill1, kill0, trap1, trap0, stall1, stall0;

  int tests = 0;
  int fails = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  stage_wb_trap #(.VECTORED_EN(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .instruction_i(insn),
    .mem_addr_i(mem_addr), .e_inst_addr_mis_i(e_im), .e_illegal_inst_i(e_ill),
    .e_break_i(e_brk), .e_ecall_i(e_ecall), .e_ld_addr_mis_i(e_ld),
    .e_st_addr_mis_i(e_st), .is_mret_i(is_mret), .xint_meip_i(meip),
    .xint_mtip_i(mtip), .xint_msip_i(msip), .plat_irq_i(plat), .csr_we_i(csr_we),
    .csr_addr_i(caddr), .csr_wdata_i(wdata), .csr_rdata_o(rdata1),
    .kill_wb_o(kill1), .trap_o(trap1), .trap_pc_o(tpc1), .stall_o(stall1));

  stage_wb_trap #(.VECTORED_EN(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .instruction_i(insn),
    .mem_addr_i(mem_addr), .e_inst_addr_mis_i(e_im), .e_illegal_inst_i(e_ill),
    .e_break_i(e_brk), .e_ecall_i(e_ecall), .e_ld_addr_mis_i(e_ld),
    .e_st_addr_mis_i(e_st), .is_mret_i(is_mret), .xint_meip_i(meip),
    .xint_mtip_i(mtip), .xint_msip_i(msip), .plat_irq_i(plat), .csr_we_i(csr_we),
    .csr_addr_i(caddr), .csr_wdata_i(wdata), .csr_rdata_o(rdata0),
    .kill_wb_o(kill0), .trap_o(trap0), .trap_pc_o(tpc0), .stall_o(stall0));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; csr_we = 1'b0; is_mret = 1'b0; insn = 32'h13;
    e_im = 1'b0; e_ill = 1'b0; e_brk = 1'b0; e_ecall = 1'b0; e_ld = 1'b0; e_st = 1'b0;
  endtask

  task automatic csr_chk(input string tag, input logic [11:0] a,
                         input logic [31:0] e1, input logic [31:0] e0);
    caddr = a;
    #1;
    check({tag, "_v1"}, rdata1, e1);
    check({tag, "_v0"}, rdata0, e0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    valid = 1'b1; csr_we = 1'b1; caddr = a; wdata = d; pc = 32'h0;
    cyc();
    idle();
  endtask

  // Retire one trapping instruction (flags set by the caller) and check the
  // redirect that follows on the next cycle.
  task automatic trap_step(input string tag, input logic [31:0] p,
                           input logic [31:0] e1, input logic [31:0] e0);
    logic [31:0] x1, x0;
    pc = p; valid = 1'b1;
    #1;
    check({tag, "_kill1"}, kill1, 1);
    check({tag, "_kill0"}, kill0, 1);
    q1.push_back(e1);
    q0.push_back(e0);
    cyc();
    idle();
    check({tag, "_trap1"}, trap1, 1);
    check({tag, "_trap0"}, trap0, 1);
    x1 = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
    x0 = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_tpc1"}, tpc1, x1);
    check({tag, "_tpc0"}, tpc0, x0);
    check({tag, "_stall_a"}, stall1, 1);
  endtask

  task automatic flush_wait(input string tag);
    cyc();
    check({tag, "_trap_once"}, trap1, 0);
    check({tag, "_stall_b"}, stall1, 1);
    cyc();
    check({tag, "_stall_end"}, stall1, 0);
  endtask

  initial begin
    rst = 1'b1; meip = 1'b0; mtip = 1'b0; msip = 1'b0; plat = 4'b0;
    pc = 32'h0; mem_addr = 32'h0; wdata = 32'h0; caddr = 12'h0;
    idle();
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    check("rst_stall", stall1, 0);
    check("rst_trap", trap1, 0);
    check("rst_tpc", tpc1, 0);
    csr_chk("rst_mstatus", A_MSTATUS, 32'h1800, 32'h1800);
    csr_chk("rst_mtvec", A_MTVEC, 32'h100, 32'h100);
    csr_chk("rst_mie", A_MIE, 32'h0, 32'h0);
    csr_chk("rst_mcause", A_MCAUSE, 32'h0, 32'h0);

    // External interrupt, plus FLUSH ignoring a retiring ecall
    wr(A_MIE, 32'h800);
    wr(A_MSTATUS, 32'h8);
    csr_chk("mstatus_mie", A_MSTATUS, 32'h1808, 32'h1808);
    meip = 1'b1;
    csr_chk("mip_mirror", A_MIP, 32'h800, 32'h800);
    cyc();
    check("no_valid_no_trap", trap1, 0);
    trap_step("mei", 32'h40, 32'h100, 32'h100);
    e_ecall = 1'b1; valid = 1'b1; pc = 32'h44;
    #1;
    check("flush_kill", kill1, 0);
    cyc();
    idle();
    check("flush_trap_once", trap1, 0);
    check("flush_stall_b", stall1, 1);
    cyc();
    check("flush_stall_end", stall1, 0);
    check("flush_ecall_ignored", trap1, 0);
    meip = 1'b0;
    csr_chk("mei_mcause", A_MCAUSE, 32'h8000000B, 32'h8000000B);
    csr_chk("mei_mepc", A_MEPC, 32'h40, 32'h40);
    csr_chk("mei_mstatus", A_MSTATUS, 32'h1880, 32'h1880);
    csr_chk("mei_mtval", A_MTVAL, 32'h0, 32'h0);

    // mret back to mepc
    is_mret = 1'b1;
    trap_step("mret", 32'h80, 32'h40, 32'h40);
    flush_wait("mret");
    csr_chk("mret_mstatus", A_MSTATUS, 32'h1888, 32'h1888);

    // Vectored timer interrupt
    wr(A_MTVEC, 32'h201);
    csr_chk("mtvec_mode", A_MTVEC, 32'h201, 32'h200);
    wr(A_MIE, 32'h80);
    mtip = 1'b1;
    trap_step("mti_vec", 32'h100, 32'h21C, 32'h200);
    flush_wait("mti_vec");
    mtip = 1'b0;
    csr_chk("mti_mcause", A_MCAUSE, 32'h80000007, 32'h80000007);

    // Illegal beats load-misaligned
    wr(A_MSTATUS, 32'h8);
    e_ill = 1'b1; e_ld = 1'b1; insn = 32'hFFFFFFFF; mem_addr = 32'h1234;
    trap_step("exc_ill", 32'h200, 32'h200, 32'h200);
    flush_wait("exc_ill");
    csr_chk("ill_mcause", A_MCAUSE, 32'h2, 32'h2);
    csr_chk("ill_mtval", A_MTVAL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    csr_chk("ill_mepc", A_MEPC, 32'h200, 32'h200);

    // Interrupt beats the same exceptions
    wr(A_MIE, 32'h800);
    wr(A_MSTATUS, 32'h8);
    meip = 1'b1;
    e_ill = 1'b1; e_ld = 1'b1; insn = 32'hFFFFFFFF;
    trap_step("irq_beats_exc", 32'h204, 32'h22C, 32'h200);
    flush_wait("irq_beats_exc");
    meip = 1'b0;
    csr_chk("ibe_mcause", A_MCAUSE, 32'h8000000B, 32'h8000000B);
    csr_chk("ibe_mtval", A_MTVAL, 32'h0, 32'h0);

    // Load misaligned beats store misaligned
    e_ld = 1'b1; e_st = 1'b1; mem_addr = 32'h1003;
    trap_step("ld_mis", 32'h300, 32'h200, 32'h200);
    flush_wait("ld_mis");
    csr_chk("ld_mcause", A_MCAUSE, 32'h4, 32'h4);
    csr_chk("ld_mtval", A_MTVAL, 32'h1003, 32'h1003);

    // Platform lines 0 and 1 both pending: line 0 wins
    wr(A_MIE, 32'h30000);
    wr(A_MSTATUS, 32'h8);
    plat = 4'b0011;
    trap_step("plat", 32'h400, 32'h240, 32'h200);
    flush_wait("plat");
    plat = 4'b0000;
    csr_chk("plat_mcause", A_MCAUSE, 32'h80000010, 32'h80000010);

    // CSR write dropped under ecall
    e_ecall = 1'b1; csr_we = 1'b1; caddr = A_MSCRATCH; wdata = 32'hA5;
    trap_step("ecall_csr", 32'h500, 32'h200, 32'h200);
    flush_wait("ecall_csr");
    csr_chk("ecall_mscratch", A_MSCRATCH, 32'h0, 32'h0);
    csr_chk("ecall_mcause", A_MCAUSE, 32'hB, 32'hB);
    wr(A_MSCRATCH, 32'hA5);
    csr_chk("mscratch_wr", A_MSCRATCH, 32'hA5, 32'hA5);
    wr(A_MEPC, 32'h43);
    csr_chk("mepc_align", A_MEPC, 32'h40, 32'h40);
    wr(A_MIP, 32'hFFFF);
    csr_chk("mip_ro", A_MIP, 32'h0, 32'h0);

    // Reset during the first FLUSH cycle
    e_brk = 1'b1;
    trap_step("break", 32'h600, 32'h200, 32'h200);
    rst = 1'b1;
    cyc();
    check("rstf_stall", stall1, 0);
    check("rstf_trap", trap1, 0);
    check("rstf_tpc", tpc1, 0);
    csr_chk("rstf_mtvec", A_MTVEC, 32'h100, 32'h100);
    csr_chk("rstf_mstatus", A_MSTATUS, 32'h1800, 32'h1800);
    csr_chk("rstf_mcause", A_MCAUSE, 32'h0, 32'h0);
    rst = 1'b0;
    cyc();
    check("rstf_stall_after", stall1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
